uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - Serial transmitter: the outbound counterpart of the receiver datapath/RCU on the same UART link.
// - Accepts one parallel word per handshake and drives an async serial frame on serial_out.
// - Frame order: start(0), data LSB-first, optional parity, stop(1).
// - Sits between the host-side write interface and the TX pin; the line idles high.
// PARAMETERS
// - DATA_BITS     8   data bits per frame; legal 5..9
// - CLKS_PER_BIT  10  clk cycles per serial bit; legal >= 2
// - STOP_BITS     1   stop bits per frame; legal 1 or 2
// PORTS
// - clk           in   1          system clock, rising edge
// - n_rst         in   1          asynchronous, active-low reset
// - tx_start      in   1          request to send tx_data; sampled only while tx_ready=1
// - tx_data       in   DATA_BITS  word to send; captured on the accepting edge
// - tx_ready      out  1          1 only in IDLE; a new request can be accepted
// - tx_done       out  1          one-cycle pulse when the final stop-bit period ends
// - serial_out    out  1          registered serial line; idle/stop=1, start=0
// BEHAVIOUR
// - Reset (async, any time incl. mid-frame):
//   - state=IDLE, serial_out=1, tx_done=0, tx_ready=1.
//   - Shift register, timer and bit count cleared.
//   - An in-flight frame is abandoned and no tx_done is issued.
// - FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
// - IDLE:
//   - tx_start=1 at edge k: latch tx_data, go to START.
//   - serial_out=0 from edge k; tx_ready=0 from edge k.
//   - tx_start=0: stay in IDLE, serial_out=1.
// - Each bit is held exactly CLKS_PER_BIT cycles.
//   - bit_tick marks the last cycle of a bit period; state changes and bit advances happen on bit_tick edges only.
// - START -> DATA on bit_tick.
// - DATA:
//   - serial_out = shift_reg[0]; shift right on bit_tick.
//   - After DATA_BITS ticks go to PARITY (macro) or STOP.
// - STOP:
//   - serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - tx_done=1 in the last cycle; next state IDLE.
// - tx_start while tx_ready=0 is ignored (not queued); tx_data changes mid-frame have no effect.
// - Back-to-back: a request held high is accepted on the first IDLE cycle after tx_done.
//   - Guarantees one idle-high cycle between frames.
// - Frame length from acceptance edge to tx_done cycle, inclusive:
//   - (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity, else 0.
// - Widths:
//   - timer: $clog2(CLKS_PER_BIT) bits, wraps to 0 on bit_tick.
//   - bit counter: $clog2(DATA_BITS+1) bits, cleared on entry to START.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - PARITY state inserted after DATA; serial_out = even parity (^ of latched data) for one bit period.
// - UART_TX_PARITY_EN undefined:
//   - no PARITY state or logic; DATA goes straight to STOP.
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum logic [2:0] tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}.
//   - localparam logic LINE_IDLE = 1'b1.
// - Sub-module tx_bit_timer:
//   - params CLKS_PER_BIT; inputs clk, n_rst, clear, enable; output bit_tick.
//   - Enabled in every non-IDLE state; cleared in IDLE.
// - Top level holds the FSM, shift register, bit counter, parity bit and the serial_out register.
// TESTING (DATA_BITS=8, CLKS_PER_BIT=10, STOP_BITS=1 unless noted)
// - Send 8'hA5, no parity:
//   - serial_out = 0|1,0,1,0,0,1,0,1|1, each bit 10 cycles.
//   - tx_done 1 cycle, 100 cycles after acceptance; tx_ready high the next cycle.
// - UART_TX_PARITY_EN, send 8'hA5 then 8'h01:
//   - parity bits 0 then 1; frames are 110 cycles each.
// - tx_start held high with 8'hFF then 8'h00:
//   - two frames, exactly one idle-high cycle between them.
//   - Pulse tx_start mid-frame: ignored, no third frame.
// - n_rst low during DATA bit 3 of 8'h3C:
//   - serial_out=1 immediately, no tx_done, tx_ready=1.
//   - A fresh send of 8'h3C after release completes normally.
// - STOP_BITS=2, CLKS_PER_BIT=4, send 8'h80:
//   - stop high 8 cycles; tx_done at cycle 44.
//   - Verify each bit width is exactly 4 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared TX state encoding and line-level constants for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: host write handshake and TX pin of the UART transmitter
// master: drives tx_start/tx_data, observes tx_ready/tx_done/serial_out
// slave:  the transmitter side of the same signals
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 serial_out;
  modport master (output tx_start, tx_data, input tx_ready, tx_done, serial_out);
  modport slave (input tx_start, tx_data, output tx_ready, tx_done, serial_out);
endinterface

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: counts clk cycles within one serial bit, bit_tick on the last cycle
// ports: clk, n_rst (async active-low), clear (hold at 0), enable (count), bit_tick (out)
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_tick = enable && cnt_q == W'(CLKS_PER_BIT - 1);
  assign cnt_d = (clear || bit_tick) ? '0 : enable ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, frame = start, data LSB-first, optional even parity, stop bits
// ports: clk, n_rst (async active-low), bus (uart_tx_if.slave: tx_start, tx_data, tx_ready, tx_done, serial_out)
// build option: UART_TX_PARITY_EN inserts an even parity bit after the data bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1
) (
  input logic       clk,
  input logic       n_rst,
  uart_tx_if.slave  bus
);
  localparam int BW = $clog2(DATA_BITS + 1);
  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 bit_tick, last_data, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif
  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state_q == TX_IDLE),
    .enable   (state_q != TX_IDLE),
    .bit_tick (bit_tick)
  );
  assign last_data = bit_cnt_q == BW'(DATA_BITS - 1);
  assign last_stop = bit_cnt_q == BW'(STOP_BITS - 1);
  assign bus.tx_ready   = state_q == TX_IDLE;
  assign bus.tx_done    = state_q == TX_STOP && bit_tick && last_stop;
  assign bus.serial_out = serial_q;
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      TX_IDLE:
        if (bus.tx_start) begin
          state_d   = TX_START;
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
        end
      TX_START:
        if (bit_tick) state_d = TX_DATA;
      TX_DATA:
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = last_data ? '0 : bit_cnt_q + BW'(1);
`ifdef UART_TX_PARITY_EN
          state_d   = last_data ? TX_PARITY : TX_DATA;
`else
          state_d   = last_data ? TX_STOP : TX_DATA;
`endif
        end
`ifdef UART_TX_PARITY_EN
      TX_PARITY:
        if (bit_tick) state_d = TX_STOP;
`endif
      TX_STOP:
        if (bit_tick) begin
          bit_cnt_d = last_stop ? '0 : bit_cnt_q + BW'(1);
          state_d   = last_stop ? TX_IDLE : TX_STOP;
        end
      default: state_d = TX_IDLE;
    endcase
    // serial_out is registered, so it is derived from the state being entered
    serial_d = state_d == TX_START ? 1'b0 : state_d == TX_DATA ? shift_d[0] : LINE_IDLE;
`ifdef UART_TX_PARITY_EN
    if (state_d == TX_PARITY) serial_d = parity_q;
`endif
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) parity_q <= 1'b0;
    else if (state_q == TX_IDLE && bus.tx_start) parity_q <= ^bus.tx_data;
`endif
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx against a per-cycle expected line waveform
module tb_uart_tx;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int errors = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  always #5 clk = ~clk;
  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(10), .STOP_BITS(1)) dut0 (.clk(clk), .n_rst(n_rst), .bus(if0));
  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));

  function automatic logic obs_ser(int inst);
    return inst != 0 ? if1.serial_out : if0.serial_out;
  endfunction
  function automatic logic obs_rdy(int inst);
    return inst != 0 ? if1.tx_ready : if0.tx_ready;
  endfunction
  function automatic logic obs_done(int inst);
    return inst != 0 ? if1.tx_done : if0.tx_done;
  endfunction
  task automatic set_start(int inst, logic s);
    if (inst != 0) if1.tx_start = s;
    else if0.tx_start = s;
  endtask
  task automatic set_data(int inst, logic [7:0] d);
    if (inst != 0) if1.tx_data = d;
    else if0.tx_data = d;
  endtask

  task automatic check_idle(int inst, int cycles, string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (obs_ser(inst) !== 1'b1 || obs_rdy(inst) !== 1'b1 || obs_done(inst) !== 1'b0) begin
        errors++;
        $display("FAIL %s idle cycle %0d: serial/ready/done=%b%b%b expected 110", name, i,
                 obs_ser(inst), obs_rdy(inst), obs_done(inst));
      end
    end
  endtask

  task automatic accept(int inst, logic [7:0] d, string name);
    int k = 0;
    @(negedge clk);
    while (obs_rdy(inst) !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL %s ready timeout: tx_ready=%b expected 1", name, obs_rdy(inst));
    end
    set_data(inst, d);
    set_start(inst, 1'b1);
  endtask

  // expected line: every frame bit repeated for its bit period; tx_done only in the final cycle
  task automatic check_frame(int inst, logic [7:0] d, bit keep, logic [7:0] nd, bit pulse, string name);
    int cpb = inst != 0 ? 4 : 10;
    int sb = inst != 0 ? 2 : 1;
    int n;
    logic exp_q[$];
    for (int b = 0; b < 1 + 8 + P + sb; b++) begin
      logic v;
      v = b == 0 ? 1'b0 : b <= 8 ? d[b-1] : (P == 1 && b == 9) ? ^d : 1'b1;
      repeat (cpb) exp_q.push_back(v);
    end
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      checks++;
      if (obs_ser(inst) !== exp_q[i-1] || obs_done(inst) !== (i == n) || obs_rdy(inst) !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d/%0d: serial/done/ready=%b%b%b expected %b%b0", name, i, n,
                 obs_ser(inst), obs_done(inst), obs_rdy(inst), exp_q[i-1], i == n);
      end
      if (!keep) set_start(inst, pulse && i == n / 2);
      if (i == 3) set_data(inst, nd);
    end
  endtask

  task automatic test_reset;
    set_start(0, 1'b0); set_start(1, 1'b0);
    set_data(0, 8'h00); set_data(1, 8'h00);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (obs_ser(j) !== 1'b1 || obs_rdy(j) !== 1'b1 || obs_done(j) !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: serial/ready/done=%b%b%b expected 110", j, obs_ser(j), obs_rdy(j), obs_done(j));
      end
    end
    n_rst = 1'b1;
    check_idle(0, 3, "reset0");
    check_idle(1, 3, "reset1");
  endtask

  task automatic test_a5;
    accept(0, 8'hA5, "a5");
    check_frame(0, 8'hA5, 1'b0, 8'h5A, 1'b0, "a5");
    check_idle(0, 1, "a5_after");
  endtask

  task automatic test_parity_pair;
    accept(0, 8'hA5, "par_a5");
    check_frame(0, 8'hA5, 1'b0, 8'hFF, 1'b0, "par_a5");
    accept(0, 8'h01, "par_01");
    check_frame(0, 8'h01, 1'b0, 8'h00, 1'b0, "par_01");
    check_idle(0, 1, "par_after");
  endtask

  task automatic test_back_to_back;
    accept(0, 8'hFF, "b2b_ff");
    check_frame(0, 8'hFF, 1'b1, 8'h00, 1'b0, "b2b_ff");
    check_idle(0, 1, "b2b_gap");
    check_frame(0, 8'h00, 1'b0, 8'h77, 1'b1, "b2b_00");
    check_idle(0, 30, "b2b_no_third");
  endtask

  task automatic test_reset_mid;
    accept(0, 8'h3C, "rstmid");
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (44) @(negedge clk);
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if (if0.serial_out !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid async: serial/ready/done=%b%b%b expected 110", if0.serial_out, if0.tx_ready, if0.tx_done);
    end
    check_idle(0, 3, "rstmid_held");
    n_rst = 1'b1;
    check_idle(0, 20, "rstmid_released");
    accept(0, 8'h3C, "rstmid_resend");
    check_frame(0, 8'h3C, 1'b0, 8'hC3, 1'b0, "rstmid_resend");
    check_idle(0, 1, "rstmid_after");
  endtask

  task automatic test_stop2;
    accept(1, 8'h80, "stop2");
    check_frame(1, 8'h80, 1'b0, 8'h01, 1'b0, "stop2");
    check_idle(1, 1, "stop2_after");
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int inst = r % 2;
      logic [7:0] d = 8'($urandom);
      logic [7:0] nd = 8'($urandom);
      accept(inst, d, "rand");
      check_frame(inst, d, 1'b0, nd, 1'($urandom_range(0, 1)), "rand");
      check_idle(inst, 1, "rand_after");
    end
  endtask

  initial begin
    test_reset;
    test_a5;
    test_parity_pair;
    test_back_to_back;
    test_reset_mid;
    test_stop2;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
